vga_timing_generator: RTL and testbench

- Produces VGA raster timing: horizontal/vertical sync, draw enable, and visible-area pixel coordinates.
- Drives the scanline inputs (draw enable, X, Y) of the image driver that produces RGB, and drives the HSYNC/VSYNC pins directly.
- One pixel counter and one line counter, advanced by a pixel-clock enable, with fully registered outputs.

---
 rtl/vga_timing_generator.sv | 164 ++++++++++++++++
 tb/tb_vga_timing_generator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// VGA raster timing generator.
// One pixel counter and one line counter step on the pixel-clock enable.
// The next counter values are decoded and registered together with the
// counters, so every output lines up with the counter position it describes.
module vga_timing_generator #(
  parameter int p_H_VISIBLE_AREA   = 640,
  parameter int p_H_FRONT_PORCH    = 16,
  parameter int p_H_SYNC_PULSE     = 96,
  parameter int p_H_BACK_PORCH     = 48,
  parameter int p_V_VISIBLE_AREA   = 480,
  parameter int p_V_FRONT_PORCH    = 10,
  parameter int p_V_SYNC_PULSE     = 2,
  parameter int p_V_BACK_PORCH     = 33,
  parameter int p_SYNC_ACTIVE_HIGH = 0,
  localparam int XW = ($clog2(p_H_VISIBLE_AREA) > 0) ? $clog2(p_H_VISIBLE_AREA) : 1,
  localparam int YW = ($clog2(p_V_VISIBLE_AREA) > 0) ? $clog2(p_V_VISIBLE_AREA) : 1
) (
  input  logic          i_CLK,
  input  logic          i_RESET,
  input  logic          i_PIXEL_EN,
  output logic          o_HSYNC,
  output logic          o_VSYNC,
  output logic          o_DRAW_ENABLE,
  output logic [XW-1:0] o_SCANLINE_X,
  output logic [YW-1:0] o_SCANLINE_Y,
  output logic          o_LINE_START,
  output logic          o_FRAME_START
);

  localparam int H_TOTAL = p_H_VISIBLE_AREA + p_H_FRONT_PORCH + p_H_SYNC_PULSE + p_H_BACK_PORCH;
  localparam int V_TOTAL = p_V_VISIBLE_AREA + p_V_FRONT_PORCH + p_V_SYNC_PULSE + p_V_BACK_PORCH;
  localparam int HW = ($clog2(H_TOTAL) > 0) ? $clog2(H_TOTAL) : 1;
  localparam int VW = ($clog2(V_TOTAL) > 0) ? $clog2(V_TOTAL) : 1;

  // Region boundaries; all fit in the counter width because each back porch is at least 1.
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END  = HW'(p_H_VISIBLE_AREA);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(p_H_VISIBLE_AREA + p_H_FRONT_PORCH);
  localparam logic [HW-1:0] H_SYNC_END = HW'(p_H_VISIBLE_AREA + p_H_FRONT_PORCH + p_H_SYNC_PULSE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END  = VW'(p_V_VISIBLE_AREA);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(p_V_VISIBLE_AREA + p_V_FRONT_PORCH);
  localparam logic [VW-1:0] V_SYNC_END = VW'(p_V_VISIBLE_AREA + p_V_FRONT_PORCH + p_V_SYNC_PULSE);

  localparam logic SYNC_ON  = (p_SYNC_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
  localparam logic SYNC_OFF = (p_SYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  // Low after reset until the first released edge, which only loads the (0,0)
  // decode; counters must not move on that edge so outputs match them.
  logic          started_q, started_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          draw_q, draw_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          advance_s;
  logic          h_vis_s;
  logic          v_vis_s;

  // Next counter values, start pulses and region decode of the next position.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    started_d     = 1'b1;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    advance_s     = i_PIXEL_EN & started_q;

    if (advance_s) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + VW'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
    end

    if (!started_q) begin
      line_start_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (advance_s && (h_cnt_d == '0)) begin
      line_start_d  = 1'b1;
      frame_start_d = (v_cnt_d == '0);
    end else begin
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end

    h_vis_s = (h_cnt_d < H_VIS_END);
    v_vis_s = (v_cnt_d < V_VIS_END);
    draw_d  = h_vis_s & v_vis_s;

    if (h_vis_s) begin
      x_d = h_cnt_d[XW-1:0];
    end else begin
      x_d = '0;
    end

    if (v_vis_s) begin
      y_d = v_cnt_d[YW-1:0];
    end else begin
      y_d = '0;
    end

    if ((h_cnt_d >= H_SYNC_BEG) && (h_cnt_d < H_SYNC_END)) begin
      hsync_d = SYNC_ON;
    end else begin
      hsync_d = SYNC_OFF;
    end

    if ((v_cnt_d >= V_SYNC_BEG) && (v_cnt_d < V_SYNC_END)) begin
      vsync_d = SYNC_ON;
    end else begin
      vsync_d = SYNC_OFF;
    end
  end

  // Counter and output registers with synchronous reset.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      started_q     <= 1'b0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      draw_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      started_q     <= started_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      draw_q        <= draw_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_HSYNC       = hsync_q;
  assign o_VSYNC       = vsync_q;
  assign o_DRAW_ENABLE = draw_q;
  assign o_SCANLINE_X  = x_q;
  assign o_SCANLINE_Y  = y_q;
  assign o_LINE_START  = line_start_q;
  assign o_FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default 640x480 timing (horizontal checks),
// a scaled 64x48 timing (vertical/frame checks) and a tiny active-high timing.
module tb_vga_timing_generator;

  logic clk;
  logic rst_def, en_def, rst_mid, en_mid, rst_sml, en_sml;

  logic hs_def, vs_def, de_def, ls_def, fs_def;
  logic [9:0] x_def;
  logic [8:0] y_def;
  logic hs_mid, vs_mid, de_mid, ls_mid, fs_mid;
  logic [5:0] x_mid;
  logic [5:0] y_mid;
  logic hs_sml, vs_sml, de_sml, ls_sml, fs_sml;
  logic [1:0] x_sml;
  logic [1:0] y_sml;

  vga_timing_generator u_def (
    .i_CLK(clk), .i_RESET(rst_def), .i_PIXEL_EN(en_def),
    .o_HSYNC(hs_def), .o_VSYNC(vs_def), .o_DRAW_ENABLE(de_def),
    .o_SCANLINE_X(x_def), .o_SCANLINE_Y(y_def),
    .o_LINE_START(ls_def), .o_FRAME_START(fs_def)
  );

  vga_timing_generator #(
    .p_H_VISIBLE_AREA(64), .p_H_FRONT_PORCH(4), .p_H_SYNC_PULSE(8), .p_H_BACK_PORCH(4),
    .p_V_VISIBLE_AREA(48), .p_V_FRONT_PORCH(2), .p_V_SYNC_PULSE(2), .p_V_BACK_PORCH(3),
    .p_SYNC_ACTIVE_HIGH(0)
  ) u_mid (
    .i_CLK(clk), .i_RESET(rst_mid), .i_PIXEL_EN(en_mid),
    .o_HSYNC(hs_mid), .o_VSYNC(vs_mid), .o_DRAW_ENABLE(de_mid),
    .o_SCANLINE_X(x_mid), .o_SCANLINE_Y(y_mid),
    .o_LINE_START(ls_mid), .o_FRAME_START(fs_mid)
  );

  vga_timing_generator #(
    .p_H_VISIBLE_AREA(4), .p_H_FRONT_PORCH(1), .p_H_SYNC_PULSE(2), .p_H_BACK_PORCH(1),
    .p_V_VISIBLE_AREA(3), .p_V_FRONT_PORCH(1), .p_V_SYNC_PULSE(1), .p_V_BACK_PORCH(1),
    .p_SYNC_ACTIVE_HIGH(1)
  ) u_sml (
    .i_CLK(clk), .i_RESET(rst_sml), .i_PIXEL_EN(en_sml),
    .o_HSYNC(hs_sml), .o_VSYNC(vs_sml), .o_DRAW_ENABLE(de_sml),
    .o_SCANLINE_X(x_sml), .o_SCANLINE_Y(y_sml),
    .o_LINE_START(ls_sml), .o_FRAME_START(fs_sml)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic de;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } obs_t;

  typedef struct {
    int   t;
    obs_t o;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   tcur    = 0;

  // flags = {hs, vs, ls, fs}
  function automatic obs_t mko(input logic de, input int x, input int y, input logic [3:0] f);
    obs_t o;
    o.de = de; o.x = x; o.y = y;
    o.hs = f[3]; o.vs = f[2]; o.ls = f[1]; o.fs = f[0];
    return o;
  endfunction

  function automatic vec_t mkv(input int t, input obs_t o);
    vec_t v;
    v.t = t; v.o = o;
    return v;
  endfunction

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    case (sel)
      0: o = mko(de_def, int'(x_def), int'(y_def), {hs_def, vs_def, ls_def, fs_def});
      1: o = mko(de_mid, int'(x_mid), int'(y_mid), {hs_mid, vs_mid, ls_mid, fs_mid});
      default: o = mko(de_sml, int'(x_sml), int'(y_sml), {hs_sml, vs_sml, ls_sml, fs_sml});
    endcase
    return o;
  endfunction

  task automatic set_en(input int sel, input logic v);
    case (sel)
      0: en_def = v;
      1: en_mid = v;
      default: en_sml = v;
    endcase
  endtask

  task automatic set_rst(input int sel, input logic v);
    case (sel)
      0: rst_def = v;
      1: rst_mid = v;
      default: rst_sml = v;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_obs(input string name, input int t, input obs_t a, input obs_t e);
    n_total++;
    if (a.de === e.de && a.x == e.x && a.y == e.y && a.hs === e.hs &&
        a.vs === e.vs && a.ls === e.ls && a.fs === e.fs) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0d: got de=%0b x=%0d y=%0d hs=%0b vs=%0b ls=%0b fs=%0b expected de=%0b x=%0d y=%0d hs=%0b vs=%0b ls=%0b fs=%0b",
               name, t, a.de, a.x, a.y, a.hs, a.vs, a.ls, a.fs,
               e.de, e.x, e.y, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  // Walk the vector table in time order; t counts negedges since the release edge.
  task automatic run_table(input int sel, input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      while (tcur < tbl[i].t) begin
        @(negedge clk);
        tcur++;
      end
      check_obs(name, tcur, get_obs(sel), tbl[i].o);
    end
    tbl.delete();
  endtask

  // Line-level measurement: period, HSYNC placement/width, pulse width, hold between enables.
  task automatic run_h(input int sel, input int div, input int n_cyc, input int period,
                       input int sb, input int se, input logic on, input string name);
    int since = -1, lines = 0, hs_cnt = 0, pos_err = 0, stab_err = 0, wide_err = 0;
    logic prev_ls = 1'b0;
    obs_t o, prev;
    prev = get_obs(sel);
    for (int c = 0; c < n_cyc; c++) begin
      set_en(sel, (c % div) == 0);
      @(negedge clk);
      o = get_obs(sel);
      if (o.ls && prev_ls) wide_err++;
      if (o.ls) begin
        if (since >= 0) begin
          chk({name, "_line_period"}, since + 1, period);
          chk({name, "_hsync_clocks"}, hs_cnt, (se - sb) * div);
        end
        since = 0; hs_cnt = 0; lines++;
      end else if (since >= 0) begin
        since++;
      end
      if (since >= 0) begin
        if (o.hs !== (((since / div) >= sb && (since / div) < se) ? on : ~on)) pos_err++;
        if (o.hs === on) hs_cnt++;
        if ((since % div) != 0 && (o.de !== prev.de || o.x != prev.x || o.y != prev.y ||
            o.hs !== prev.hs || o.vs !== prev.vs)) stab_err++;
      end
      prev = o;
      prev_ls = o.ls;
    end
    chk({name, "_lines_seen_ge3"}, int'(lines >= 3), 1);
    chk({name, "_hsync_position_errors"}, pos_err, 0);
    chk({name, "_hold_errors"}, stab_err, 0);
    chk({name, "_wide_line_start"}, wide_err, 0);
  endtask

  // Frame-level measurement with the enable held at 1.
  task automatic run_frame(input int sel, input int n_cyc, input int period, input logic on,
                           input int vs_exp, input int de_exp, input int ymax_exp, input string name);
    int since = -1, frames = 0, vs_cnt = 0, de_cnt = 0, ymax = 0;
    obs_t o;
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clk);
      o = get_obs(sel);
      if (o.fs) begin
        if (since >= 0) begin
          chk({name, "_frame_period"}, since + 1, period);
          chk({name, "_vsync_clocks"}, vs_cnt, vs_exp);
          chk({name, "_draw_clocks"}, de_cnt, de_exp);
          chk({name, "_max_y"}, ymax, ymax_exp);
        end
        since = 0; vs_cnt = 0; de_cnt = 0; ymax = 0; frames++;
      end else if (since >= 0) begin
        since++;
      end
      if (since >= 0) begin
        if (o.vs === on) vs_cnt++;
        if (o.de === 1'b1) begin
          de_cnt++;
          if (o.y > ymax) ymax = o.y;
        end
      end
    end
    chk({name, "_frames_seen_ge3"}, int'(frames >= 3), 1);
  endtask

  initial begin
    rst_def = 1'b1; en_def = 1'b1;
    rst_mid = 1'b1; en_mid = 1'b1;
    rst_sml = 1'b1; en_sml = 1'b0;

    // ---------------- default timing, horizontal behaviour ----------------
    repeat (3) @(negedge clk);
    check_obs("def_reset", 0, get_obs(0), mko(1'b0, 0, 0, 4'b1100));
    rst_def = 1'b0;
    @(negedge clk);
    tcur = 0;
    tbl.push_back(mkv(0,    mko(1'b1, 0,   0, 4'b1111)));
    tbl.push_back(mkv(1,    mko(1'b1, 1,   0, 4'b1100)));
    tbl.push_back(mkv(639,  mko(1'b1, 639, 0, 4'b1100)));
    tbl.push_back(mkv(640,  mko(1'b0, 0,   0, 4'b1100)));
    tbl.push_back(mkv(655,  mko(1'b0, 0,   0, 4'b1100)));
    tbl.push_back(mkv(656,  mko(1'b0, 0,   0, 4'b0100)));
    tbl.push_back(mkv(751,  mko(1'b0, 0,   0, 4'b0100)));
    tbl.push_back(mkv(752,  mko(1'b0, 0,   0, 4'b1100)));
    tbl.push_back(mkv(799,  mko(1'b0, 0,   0, 4'b1100)));
    tbl.push_back(mkv(800,  mko(1'b1, 0,   1, 4'b1110)));
    tbl.push_back(mkv(1439, mko(1'b1, 639, 1, 4'b1100)));
    tbl.push_back(mkv(1700, mko(1'b1, 100, 2, 4'b1100)));
    run_table(0, "def_vec");

    run_h(0, 1, 2500, 800, 656, 752, 1'b0, "def_en1");
    run_h(0, 4, 10000, 3200, 656, 752, 1'b0, "def_en4");

    // Reset pulse in the middle of a line (h=700 in HSYNC, v=2).
    en_def = 1'b1;
    rst_def = 1'b1;
    @(negedge clk);
    check_obs("def_rst_a", 0, get_obs(0), mko(1'b0, 0, 0, 4'b1100));
    rst_def = 1'b0;
    @(negedge clk);
    tcur = 0;
    tbl.push_back(mkv(0,    mko(1'b1, 0, 0, 4'b1111)));
    tbl.push_back(mkv(2300, mko(1'b0, 0, 2, 4'b0100)));
    run_table(0, "def_pre_rst");
    rst_def = 1'b1;
    @(negedge clk);
    check_obs("def_midline_reset", 0, get_obs(0), mko(1'b0, 0, 0, 4'b1100));
    rst_def = 1'b0;
    @(negedge clk);
    check_obs("def_after_release", 0, get_obs(0), mko(1'b1, 0, 0, 4'b1111));
    @(negedge clk);
    check_obs("def_after_release", 1, get_obs(0), mko(1'b1, 1, 0, 4'b1100));
    rst_def = 1'b1;

    // ---------------- scaled timing, vertical behaviour ----------------
    rst_mid = 1'b0;
    @(negedge clk);
    tcur = 0;
    tbl.push_back(mkv(0,    mko(1'b1, 0,  0,  4'b1111)));
    tbl.push_back(mkv(3823, mko(1'b1, 63, 47, 4'b1100)));
    tbl.push_back(mkv(3840, mko(1'b0, 0,  0,  4'b1110)));
    tbl.push_back(mkv(4068, mko(1'b0, 0,  0,  4'b0000)));
    tbl.push_back(mkv(4159, mko(1'b0, 0,  0,  4'b1000)));
    tbl.push_back(mkv(4160, mko(1'b0, 0,  0,  4'b1110)));
    tbl.push_back(mkv(4399, mko(1'b0, 0,  0,  4'b1100)));
    tbl.push_back(mkv(4400, mko(1'b1, 0,  0,  4'b1111)));
    run_table(1, "mid_vec");
    run_frame(1, 13300, 4400, 1'b0, 160, 3072, 47, "mid");
    rst_mid = 1'b1;

    // ---------------- tiny active-high timing ----------------
    repeat (2) @(negedge clk);
    check_obs("sml_reset", 0, get_obs(2), mko(1'b0, 0, 0, 4'b0000));
    rst_sml = 1'b0;
    @(negedge clk);
    tcur = 0;
    check_obs("sml_release_en0", 0, get_obs(2), mko(1'b1, 0, 0, 4'b0011));
    @(negedge clk);
    tcur = 1;
    check_obs("sml_hold_en0", 1, get_obs(2), mko(1'b1, 0, 0, 4'b0000));
    en_sml = 1'b1;
    tbl.push_back(mkv(2,  mko(1'b1, 1, 0, 4'b0000)));
    tbl.push_back(mkv(5,  mko(1'b0, 0, 0, 4'b0000)));
    tbl.push_back(mkv(6,  mko(1'b0, 0, 0, 4'b1000)));
    tbl.push_back(mkv(7,  mko(1'b0, 0, 0, 4'b1000)));
    tbl.push_back(mkv(8,  mko(1'b0, 0, 0, 4'b0000)));
    tbl.push_back(mkv(9,  mko(1'b1, 0, 1, 4'b0010)));
    tbl.push_back(mkv(20, mko(1'b1, 3, 2, 4'b0000)));
    tbl.push_back(mkv(25, mko(1'b0, 0, 0, 4'b0010)));
    tbl.push_back(mkv(38, mko(1'b0, 0, 0, 4'b1100)));
    tbl.push_back(mkv(41, mko(1'b0, 0, 0, 4'b0010)));
    tbl.push_back(mkv(48, mko(1'b0, 0, 0, 4'b0000)));
    tbl.push_back(mkv(49, mko(1'b1, 0, 0, 4'b0011)));
    run_table(2, "sml_vec");
    run_frame(2, 150, 48, 1'b1, 8, 12, 2, "sml");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
